// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state encoding and byte/word geometry are used by the FSM and the byte packer.
package inst_loader_pkg;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = WORD_BYTES * BYTE_W;
   localparam int IDX_W      = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Byte address of word idx; the sum wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [IDX_W-1:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs four stream bytes MSB-first into one instruction word.
// 'full' flags the shift that completes the word, so the FSM can leave COLLECT on that edge.
module byte_packer
   import inst_loader_pkg::*;
(
   input  logic              clk,
   input  logic              Rst,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] din,
   output logic [WORD_W-1:0] word,
   output logic              full
);

   logic [1:0]        cnt_reg;
   logic [WORD_W-1:0] word_reg;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         cnt_reg  <= 2'd0;
         word_reg <= '0;
      end else if (clr) begin
         cnt_reg  <= 2'd0;
         word_reg <= '0;
      end else if (shift_en) begin
         cnt_reg  <= cnt_reg + 2'd1;
         word_reg <= {word_reg[WORD_W-BYTE_W-1:0], din};
      end
   end

   assign word = word_reg;
   assign full = shift_en && (cnt_reg == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction memory: packs words, writes them to
// consecutive addresses from BASE_ADDR and holds the CPU in reset meanwhile.
module inst_mem_loader
   import inst_loader_pkg::*;
#(
   parameter int          MEM_BYTES = 128,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  load_len,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              byte_ready,
   output logic [31:0]       IAddr,
   output logic [WORD_W-1:0] IDataIn,
   output logic              InsMemRW,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [31:0] MEM_WORDS = 32'(MEM_BYTES / WORD_BYTES);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [IDX_W-1:0]   len_reg, len_next;
   logic               err_reg, err_next;
   logic [31:0]        addr_reg, addr_next;

   logic               pk_clr;
   logic               pk_shift;
   logic               pk_full;
   logic [WORD_W-1:0]  pk_word;
   logic               too_long;
   logic [IDX_W-1:0]   idx_inc;

   byte_packer u_packer (
      .clk      (clk),
      .Rst      (Rst),
      .clr      (pk_clr),
      .shift_en (pk_shift),
      .din      (byte_data),
      .word     (pk_word),
      .full     (pk_full)
   );

   assign too_long = {16'd0, load_len} > MEM_WORDS;
   assign idx_inc  = idx_reg + 16'd1;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         len_reg   <= '0;
         err_reg   <= 1'b0;
         addr_reg  <= BASE_ADDR;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         len_reg   <= len_next;
         err_reg   <= err_next;
         addr_reg  <= addr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      len_next   = len_reg;
      err_next   = err_reg;
      addr_next  = addr_reg;
      pk_clr     = 1'b0;
      pk_shift   = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               if (too_long) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end else if (load_len == '0) begin
                  err_next   = 1'b0;
                  state_next = DONE;
               end else begin
                  err_next   = 1'b0;
                  len_next   = load_len;
                  idx_next   = '0;
                  pk_clr     = 1'b1;
                  state_next = COLLECT;
               end
            end
         end
         COLLECT: begin
            // abort outranks a byte handshake in the same cycle
            if (abort) begin
               pk_clr     = 1'b1;
               state_next = IDLE;
            end else if (byte_valid) begin
               pk_shift = 1'b1;
               if (pk_full) begin
                  addr_next  = word_addr(BASE_ADDR, idx_reg);
                  state_next = WRITE;
               end
            end
         end
         WRITE: begin
            if (abort) begin
               pk_clr     = 1'b1;
               state_next = IDLE;
            end else begin
               idx_next   = idx_inc;
               state_next = (idx_inc == len_reg) ? DONE : COLLECT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The address register is loaded on entry to WRITE and otherwise holds.
   assign IAddr      = addr_reg;
   assign IDataIn    = pk_word;
   assign InsMemRW   = !((state_reg == WRITE) && !abort);
   assign byte_ready = (state_reg == COLLECT);
   assign busy       = (state_reg == COLLECT) || (state_reg == WRITE);
   assign cpu_rst_n  = !busy;
   assign done       = (state_reg == DONE);
   assign err        = err_reg;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued as stimulus is
// planned and popped by a monitor whenever the DUT drives a write cycle.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        Rst;
   logic        start;
   logic [15:0] load_len;
   logic        abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [31:0] IAddr;
   logic [31:0] IDataIn;
   logic        InsMemRW;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_cyc = 0;
   logic        done_prev = 1'b0;
   logic        low_prev = 1'b0;
   logic [63:0] exp_q[$];
   logic [31:0] big_words[32];

   always #5 clk = ~clk;

   inst_mem_loader #(.MEM_BYTES(128), .BASE_ADDR(32'h0000_0000)) dut (
      .clk        (clk),
      .Rst        (Rst),
      .start      (start),
      .load_len   (load_len),
      .abort      (abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .IAddr      (IAddr),
      .IDataIn    (IDataIn),
      .InsMemRW   (InsMemRW),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
      if (InsMemRW === 1'b0) begin
         check("wr_single_cycle", {63'd0, low_prev}, 64'd0);
         check("wr_no_byte_ready", {63'd0, byte_ready}, 64'd0);
         check("wr_cpu_held", {63'd0, cpu_rst_n}, 64'd0);
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 64'(exp_q.size()), 64'd1);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            $display("write addr=%h data=%h expected addr=%h data=%h", IAddr, IDataIn, e[63:32], e[31:0]);
            check("wr_word", {IAddr, IDataIn}, e);
         end
      end
      low_prev = (InsMemRW === 1'b0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] len);
      load_len = len;
      start    = 1'b1;
      tick();
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int tmo;
      bit acc;
      if (gaps) begin
         repeat ($urandom_range(1, 2)) begin
            byte_valid = 1'b0;
            tick();
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      tmo = 0;
      acc = 1'b0;
      do begin
         @(negedge clk);
         acc = byte_ready;
         tick();
         tmo++;
      end while (!acc && tmo < 50);
      if (!acc) check("byte_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gaps);
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      if (!done) check("done_timeout", 64'd0, 64'd1);
      tick();
   endtask

   initial begin
      Rst = 1'b1; start = 1'b0; load_len = '0; abort = 1'b0;
      byte_valid = 1'b0; byte_data = '0;
      #2 Rst = 1'b0;
      #1;
      check("rst_state", {busy, done, err, byte_ready, InsMemRW, cpu_rst_n}, 64'b000011);
      check("rst_addr_data", {IAddr, IDataIn}, 64'd0);
      tick();
      Rst = 1'b1;
      tick();

      // Normal load, byte_valid held high.
      exp_q.push_back({32'h0, 32'h2011_0005});
      exp_q.push_back({32'h4, 32'h2412_000A});
      pulse_start(16'd2);
      check("start_busy_cpu", {busy, cpu_rst_n}, 64'b10);
      send_word(32'h2011_0005, 1'b0);
      send_word(32'h2412_000A, 1'b0);
      byte_valid = 1'b0;
      wait_done(20);
      check("normal_done_latency", 64'(done_cyc - start_cyc), 64'd11);
      check("normal_pending", 64'(exp_q.size()), 64'd0);
      check("normal_done_flags", {done, cpu_rst_n, err}, 64'b110);

      // Same stream with random gaps.
      exp_q.push_back({32'h0, 32'h2011_0005});
      exp_q.push_back({32'h4, 32'h2412_000A});
      pulse_start(16'd2);
      send_word(32'h2011_0005, 1'b1);
      send_word(32'h2412_000A, 1'b1);
      byte_valid = 1'b0;
      wait_done(40);
      check("bp_done_later", {63'd0, (done_cyc - start_cyc) > 11}, 64'd1);
      check("bp_pending", 64'(exp_q.size()), 64'd0);

      // Too long: error, IDLE, no write.
      pulse_start(16'd33);
      check("len33_flags", {err, busy, done}, 64'b100);
      tick();
      check("len33_idle", {err, busy, done, byte_ready}, 64'b1000);

      // Zero length: DONE one cycle after start, err cleared.
      pulse_start(16'd0);
      check("len0_flags", {done, err, busy}, 64'b100);
      tick();
      check("len0_latency", 64'(done_cyc - start_cyc), 64'd1);

      // Reload from DONE; a start while busy is ignored.
      exp_q.push_back({32'h0, 32'h0});
      pulse_start(16'd1);
      check("reload_done_drops", {done, busy}, 64'b01);
      pulse_start(16'd40);
      check("busy_start_ignored", {err, busy, done}, 64'b010);
      send_word(32'h0, 1'b0);
      byte_valid = 1'b0;
      wait_done(20);
      check("reload_done", {done, err}, 64'b10);
      check("reload_pending", 64'(exp_q.size()), 64'd0);

      // Full memory: 32 words, last at 0x7C.
      for (int i = 0; i < 32; i++) begin
         big_words[i] = $urandom;
         exp_q.push_back({32'(i * 4), big_words[i]});
      end
      pulse_start(16'd32);
      for (int i = 0; i < 32; i++) send_word(big_words[i], 1'b0);
      byte_valid = 1'b0;
      wait_done(30);
      check("len32_pending", 64'(exp_q.size()), 64'd0);
      check("len32_addr_hold", {32'd0, IAddr}, 64'h7C);

      // Abort after 6 bytes of a 3-word load, with a byte offered in the abort cycle.
      exp_q.push_back({32'h0, 32'hA1B2_C3D4});
      pulse_start(16'd3);
      send_word(32'hA1B2_C3D4, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      byte_data = 8'h77; byte_valid = 1'b1; abort = 1'b1;
      tick();
      abort = 1'b0; byte_valid = 1'b0;
      check("abort_idle", {busy, done, err, byte_ready, cpu_rst_n}, 64'b00001);
      tick();
      check("abort_pending", 64'(exp_q.size()), 64'd0);
      exp_q.push_back({32'h0, 32'hDEAD_BEEF});
      pulse_start(16'd1);
      send_word(32'hDEAD_BEEF, 1'b0);
      byte_valid = 1'b0;
      wait_done(20);
      check("after_abort_pending", 64'(exp_q.size()), 64'd0);

      // Abort during the WRITE cycle suppresses the write.
      pulse_start(16'd1);
      send_word(32'h1234_5678, 1'b0);
      byte_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_wr_idle", {busy, done}, 64'b00);
      tick();

      // Asynchronous reset during the second WRITE cycle.
      exp_q.push_back({32'h0, 32'hCAFE_0001});
      pulse_start(16'd2);
      send_word(32'hCAFE_0001, 1'b0);
      send_word(32'hCAFE_0002, 1'b0);
      byte_valid = 1'b0;
      Rst = 1'b0;
      #1;
      check("arst_ctrl", {busy, done, err, byte_ready, InsMemRW, cpu_rst_n}, 64'b000011);
      check("arst_addr_data", {IAddr, IDataIn}, 64'd0);
      tick();
      Rst = 1'b1;
      repeat (3) tick();
      check("arst_idle", {busy, done}, 64'b00);
      check("final_pending", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer side of the instruction-memory port. Accepts a byte stream over a valid/ready handshake, packs four bytes big-endian into a 32-bit instruction word, and writes the words to consecutive instruction-memory addresses. While a load is in progress it holds the single-cycle CPU in reset, then releases it so the CPU fetches the new program from `BASE_ADDR`.

## Interface
Parameters:
- `MEM_BYTES`, default 128: instruction-memory size in bytes. Must be a multiple of 4.
- `BASE_ADDR`, default 32'h00000000: byte address of the first word written.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `Rst` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse that begins a load. Sampled only in IDLE or DONE.
- `load_len` in 16: number of words to load. Latched on an accepted `start`.
- `abort` in 1: cancels the load in progress.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader can accept a byte.
- `IAddr` out 32: instruction-memory byte address.
- `IDataIn` out 32: word to write.
- `InsMemRW` out 1: 0 means write, 1 means read. The memory commits the write on the rising edge that ends a cycle with `InsMemRW`=0.
- `cpu_rst_n` out 1: CPU reset, active-low. Low while a load is in progress.
- `busy` out 1: state is COLLECT or WRITE.
- `done` out 1: level, high in DONE.
- `err` out 1: sticky length error. Cleared by the next accepted `start` or by reset.

## Operation
- States are IDLE, COLLECT, WRITE, DONE.
- **Reset values:** state=IDLE; `byte_ready`=0, `IAddr`=`BASE_ADDR`, `IDataIn`=0, `InsMemRW`=1, `cpu_rst_n`=1, `busy`=0, `done`=0, `err`=0. Word index and byte counter are 0.
- **Start, from IDLE or DONE:**
  - If `load_len` > `MEM_BYTES`/4: set `err`=1, go to IDLE, perform no write.
  - If `load_len`=0: go to DONE, perform no write.
  - Otherwise: go to COLLECT and clear the index, byte counter, `done` and `err`.
  - `start` in COLLECT or WRITE is ignored.
- **COLLECT:**
  - `byte_ready`=1.
  - A byte transfers on any edge where `byte_valid`&`byte_ready`.
  - Bytes pack MSB first: byte 0 goes to [31:24], byte 3 to [7:0].
  - When the 4th byte is accepted, go to WRITE.
- **WRITE:** lasts exactly one cycle.
  - `InsMemRW`=0, `IAddr`=`BASE_ADDR`+4·index, `IDataIn`=packed word, `byte_ready`=0.
  - Next, the index increments. If index+1 = `load_len`, go to DONE; otherwise go to COLLECT.
- **DONE:** `done`=1, `cpu_rst_n`=1. Stays until the next `start`.
- **Abort** in COLLECT or WRITE:
  - Go to IDLE at the next edge. A WRITE cycle in which `abort` is high is suppressed (`InsMemRW` forced to 1).
  - Partial bytes are discarded. `err` is unchanged. Words already written remain.
  - `abort` in IDLE or DONE is ignored. `abort` takes priority over `start` and over a byte handshake in the same cycle.
- **Outside WRITE:** `InsMemRW`=1 and `IAddr` holds its last value.
- **Widths:** index is 16 bits. The address sum is 32-bit and wraps modulo 2^32.

## Timing
- The handshake on `byte_valid`/`byte_ready` has no combinational path from `byte_valid` to `byte_ready`. `byte_ready` is a function of state only.
- From `start` accepted at edge E:
  - `busy`=1 and `cpu_rst_n`=0 during the cycle after E.
  - First byte acceptable at edge E+1.
- 4th byte accepted at edge K: the WRITE cycle is K to K+1, and the memory commits at edge K+1.
- Sustained throughput is one word per 5 cycles with `byte_valid` held high.
- Last WRITE ends at edge L: DONE, `done`=1 and `cpu_rst_n`=1 from L.
- Asynchronous `Rst` assertion mid-load returns to IDLE immediately with reset values. `cpu_rst_n` goes to 1; the CPU is held by the system reset itself.

## Structure
- Package `inst_loader_pkg`: state enum (IDLE, COLLECT, WRITE, DONE), `WORD_BYTES`=4, `BYTE_W`=8.
- Sub-module `byte_packer`: 2-bit byte counter plus 32-bit shift register, with inputs `clr` and `shift_en` and outputs `word` and `full`.
- Top-level FSM: index, address generation, `err` handling.
- Target size is about 200 lines of RTL.

## Test plan
- **Normal load:** `load_len`=2, bytes 20 11 00 05 24 12 00 0A, `byte_valid` held high. Expect:
  - Writes of 32'h20110005 at 0x00 and 32'h2412000A at 0x04, each with `InsMemRW`=0 for exactly 1 cycle.
  - `done`=1 at edge 11 after `start`.
  - `cpu_rst_n`=0 throughout the load.
- **Backpressure/gaps:** random `byte_valid` gaps on the same stream. Expect identical writes and a later `done`, and no byte accepted in a WRITE cycle.
- **Length limits:**
  - `load_len`=33 with `MEM_BYTES`=128: `err`=1, no write, state IDLE.
  - `load_len`=0: `done`=1 one cycle after `start`, no write.
  - `load_len`=32: last write at 0x7C.
- **Abort:** abort after 6 bytes of a 3-word load. Expect exactly one write (word 0), IDLE, `done`=0. A following load of 1 word writes at `BASE_ADDR`.
- **Reset mid-load:** assert `Rst` low during a WRITE cycle. All outputs take their reset values asynchronously, and no write is committed after deassertion.
- **Reload from DONE and ignored start:**
  - `start` while busy: no effect.
  - `start` in DONE with `load_len`=1 (bytes 00 00 00 00): `done` drops, one write of 0 at 0x00, then `done` rises again.
